// File: rtl/inst_buffer_pkg.sv
// inst_buffer_pkg: shared widths, entry layout and WFI encoding for the instruction buffer
package inst_buffer_pkg;
  localparam int XLEN = 32;
  localparam int IB_DEPTH = 8;
  localparam logic [31:0] WFI_ENCODING = 32'h10500073;
  typedef logic [31:0] inst_t;
  typedef struct packed {
    inst_t inst;
    logic [XLEN-1:0] pc;
  } ib_entry_t;
endpackage

// File: rtl/inst_buffer.sv
// inst_buffer: circular FIFO of {inst, pc} between fetch and decode, with flush and WFI halt
module inst_buffer
  import inst_buffer_pkg::*;
#(
  parameter int DEPTH = IB_DEPTH,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic            if_valid,
  input  inst_t           if_inst,
  input  logic [XLEN-1:0] if_pc,
  output logic            ib_ready,
  input  logic            dec_ready,
  output logic            out_valid,
  output inst_t           out_inst,
  output logic [XLEN-1:0] out_pc,
  output logic [CNT_W-1:0] count,
  output logic            halt_seen
);
  localparam int PTR_W = $clog2(DEPTH);
  ib_entry_t mem [DEPTH];
  logic [PTR_W-1:0] head, tail;
  logic full, push, pop;
  assign full = count == CNT_W'(DEPTH);
  assign ib_ready = ~full & ~halt_seen & ~flush;
  assign out_valid = count != '0;
  assign push = if_valid & ib_ready;
  assign pop = out_valid & dec_ready & ~flush;
  assign out_inst = out_valid ? mem[head].inst : '0;
  assign out_pc = out_valid ? mem[head].pc : '0;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      halt_seen <= 1'b0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      halt_seen <= 1'b0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop) head <= head + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
      if (push && if_inst == WFI_ENCODING) halt_seen <= 1'b1;
    end
  // Storage is not reset; validity comes solely from count.
  always_ff @(posedge clock)
    if (push) mem[tail] <= '{inst: if_inst, pc: if_pc};
endmodule

// File: tb/tb_inst_buffer.sv
// tb_inst_buffer: directed and randomized checks of inst_buffer against a queue model
module tb_inst_buffer;
  import inst_buffer_pkg::*;
  localparam int DEPTH = 8;
  localparam int CNT_W = 4;
  logic clock = 0, reset = 1, flush = 0, if_valid = 0, dec_ready = 0;
  logic [31:0] if_inst = '0;
  logic [XLEN-1:0] if_pc = '0;
  logic ib_ready, out_valid, halt_seen;
  logic [31:0] out_inst;
  logic [XLEN-1:0] out_pc;
  logic [CNT_W-1:0] count;
  int checks = 0, errors = 0;
  ib_entry_t mq[$];
  bit m_halt = 0;

  inst_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .flush(flush), .if_valid(if_valid), .if_inst(if_inst),
    .if_pc(if_pc), .ib_ready(ib_ready), .dec_ready(dec_ready), .out_valid(out_valid),
    .out_inst(out_inst), .out_pc(out_pc), .count(count), .halt_seen(halt_seen)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic drive(input logic v, input logic [31:0] i, input logic [XLEN-1:0] p,
                       input logic r, input logic f);
    if_valid = v; if_inst = i; if_pc = p; dec_ready = r; flush = f;
  endtask

  // Advance one clock and update the model from the inputs held across that edge.
  task automatic tick();
    bit push, pop;
    push = if_valid && mq.size() < DEPTH && !m_halt && !flush;
    pop = mq.size() > 0 && dec_ready && !flush;
    @(posedge clock); #1;
    if (flush) begin
      mq.delete(); m_halt = 0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (push) begin
        mq.push_back('{inst: if_inst, pc: if_pc});
        if (if_inst == WFI_ENCODING) m_halt = 1;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1; drive(0, 0, 0, 0, 0);
    repeat (2) @(posedge clock);
    #2 reset = 0; mq.delete(); m_halt = 0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if (ib_ready !== 1'b1) begin errors++; $display("FAIL reset_ib_ready got %b exp 1", ib_ready); end
    checks++; if (halt_seen !== 1'b0) begin errors++; $display("FAIL reset_halt got %b exp 0", halt_seen); end
    checks++; if (out_inst !== 32'h0 || out_pc !== '0) begin errors++; $display("FAIL reset_outs got %h/%h exp 0/0", out_inst, out_pc); end
  endtask

  task automatic test_first_push();
    drive(1, 32'h00500093, 0, 0, 0); tick(); drive(0, 0, 0, 0, 0); #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL first_valid got %b exp 1", out_valid); end
    checks++; if (out_inst !== 32'h00500093) begin errors++; $display("FAIL first_inst got %h exp 00500093", out_inst); end
    checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL first_pc got %h exp 0", out_pc); end
    checks++; if (count !== 4'd1) begin errors++; $display("FAIL first_count got %0d exp 1", count); end
    drive(0, 0, 0, 1, 0); tick(); drive(0, 0, 0, 0, 0); #1;
    checks++; if (count !== 4'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL first_drain got cnt %0d v %b exp 0 0", count, out_valid); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 8; i++) begin drive(1, 32'h00000013 + 32'(i << 20), 32'(4 * i), 0, 0); tick(); end
    drive(0, 0, 0, 0, 0); #1;
    checks++; if (count !== 4'd8) begin errors++; $display("FAIL fill_count got %0d exp 8", count); end
    checks++; if (ib_ready !== 1'b0) begin errors++; $display("FAIL fill_ready got %b exp 0", ib_ready); end
    drive(1, 32'h12345678, 32'h20, 0, 0); tick();
    checks++; if (count !== 4'd8) begin errors++; $display("FAIL fill_ninth got %0d exp 8", count); end
    drive(0, 0, 0, 1, 0); #1;
    for (int i = 0; i < 8; i++) begin
      checks++; if (out_pc !== 32'(4 * i)) begin errors++; $display("FAIL fill_order[%0d] got %h exp %h", i, out_pc, 4 * i); end
      tick();
    end
    drive(0, 0, 0, 0, 0); #1;
    checks++; if (count !== 4'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL fill_empty got cnt %0d v %b exp 0 0", count, out_valid); end
  endtask

  task automatic test_stream();
    int popped = 0;
    for (int i = 0; i < 3; i++) begin drive(1, $urandom, 32'h100 + 32'(4 * i), 0, 0); tick(); end
    for (int k = 0; k < 20; k++) begin
      drive(1, $urandom & 32'hFFFF_FF7F, 32'h100 + 32'(4 * (k + 3)), 1, 0); #1;
      checks++; if (out_pc !== 32'h100 + 32'(4 * popped)) begin errors++; $display("FAIL stream_pc[%0d] got %h exp %h", k, out_pc, 32'h100 + 4 * popped); end
      tick(); popped++;
      checks++; if (count !== 4'd3) begin errors++; $display("FAIL stream_count[%0d] got %0d exp 3", k, count); end
    end
    drive(0, 0, 0, 1, 0); repeat (3) tick(); drive(0, 0, 0, 0, 0);
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) begin drive(1, $urandom & 32'hFFFF_FF7F, 32'h200 + 32'(4 * i), 0, 0); tick(); end
    drive(1, 32'hDEADBEEF, 32'h99C, 0, 1); tick(); drive(0, 0, 0, 0, 0); #1;
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL flush_count got %0d exp 0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b exp 0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b0 || out_pc !== '0) begin errors++; $display("FAIL flush_dropped got v %b pc %h exp 0 0", out_valid, out_pc); end
  endtask

  task automatic test_wfi();
    drive(1, 32'h00100093, 32'h38, 0, 0); tick();
    drive(1, 32'h00200113, 32'h3C, 0, 0); tick();
    drive(1, WFI_ENCODING, 32'h40, 0, 0); tick(); drive(0, 0, 0, 0, 0); #1;
    checks++; if (halt_seen !== 1'b1) begin errors++; $display("FAIL wfi_halt got %b exp 1", halt_seen); end
    checks++; if (ib_ready !== 1'b0) begin errors++; $display("FAIL wfi_ready got %b exp 0", ib_ready); end
    drive(1, 32'h00300193, 32'h44, 0, 0); tick();
    checks++; if (count !== 4'd3) begin errors++; $display("FAIL wfi_blocked got %0d exp 3", count); end
    drive(0, 0, 0, 1, 0); #1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (out_pc !== 32'h38 + 32'(4 * i)) begin errors++; $display("FAIL wfi_drain[%0d] got %h exp %h", i, out_pc, 32'h38 + 4 * i); end
      tick();
    end
    checks++; if (count !== 4'd0 || halt_seen !== 1'b1) begin errors++; $display("FAIL wfi_after got cnt %0d h %b exp 0 1", count, halt_seen); end
    drive(0, 0, 0, 0, 1); tick(); drive(0, 0, 0, 0, 0); #1;
    checks++; if (halt_seen !== 1'b0 || ib_ready !== 1'b1) begin errors++; $display("FAIL wfi_flush got h %b r %b exp 0 1", halt_seen, ib_ready); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 4; i++) begin drive(1, $urandom & 32'hFFFF_FF7F, 32'h300 + 32'(4 * i), 0, 0); tick(); end
    drive(0, 0, 0, 0, 0);
    #2 reset = 1; #1;
    checks++; if (count !== 4'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL areset_state got cnt %0d v %b exp 0 0", count, out_valid); end
    checks++; if (out_inst !== 32'h0 || out_pc !== '0) begin errors++; $display("FAIL areset_outs got %h/%h exp 0/0", out_inst, out_pc); end
    checks++; if (ib_ready !== 1'b1 || halt_seen !== 1'b0) begin errors++; $display("FAIL areset_flags got r %b h %b exp 1 0", ib_ready, halt_seen); end
    mq.delete(); m_halt = 0;
    #1 reset = 0;
  endtask

  task automatic test_random();
    logic [31:0] ei;
    logic [XLEN-1:0] ep;
    for (int k = 0; k < 400; k++) begin
      drive($urandom_range(0, 3) != 0, ($urandom_range(0, 15) == 0) ? WFI_ENCODING : $urandom,
            $urandom, $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0);
      #1;
      ei = mq.size() > 0 ? mq[0].inst : 32'h0;
      ep = mq.size() > 0 ? mq[0].pc : '0;
      checks++; if (count !== CNT_W'(mq.size())) begin errors++; $display("FAIL rnd_count[%0d] got %0d exp %0d", k, count, mq.size()); end
      checks++; if (out_valid !== (mq.size() > 0)) begin errors++; $display("FAIL rnd_valid[%0d] got %b exp %b", k, out_valid, mq.size() > 0); end
      checks++; if (out_inst !== ei || out_pc !== ep) begin errors++; $display("FAIL rnd_head[%0d] got %h/%h exp %h/%h", k, out_inst, out_pc, ei, ep); end
      checks++; if (halt_seen !== m_halt) begin errors++; $display("FAIL rnd_halt[%0d] got %b exp %b", k, halt_seen, m_halt); end
      checks++; if (ib_ready !== (mq.size() < DEPTH && !m_halt && !flush)) begin errors++; $display("FAIL rnd_ready[%0d] got %b exp %b", k, ib_ready, mq.size() < DEPTH && !m_halt && !flush); end
      tick();
    end
    drive(0, 0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_first_push();
    test_fill();
    test_stream();
    test_flush();
    test_wfi();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
